// File: rtl/pio_edge_poller.sv
// rtl/pio_edge_poller.sv - Avalon-MM master that polls an edge-capture PIO and queues captured events.
module pio_edge_poller #(
  parameter int POLL_DIV   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_capture,
  output logic [7:0]       evt_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic             irq
);

  localparam int PTR_W = LVL_W - 1;
  localparam int TMR_W = $clog2(POLL_DIV);

  typedef enum logic [2:0] {
    IDLE, CAP_REQ, CAP_SAMPLE, DAT_REQ, DAT_SAMPLE, CLR, PUSH
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [7:0]       cap_reg, dat_reg;
  logic             start, push, pop;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      last_q, head;
  logic             unused_readdata;

  assign unused_readdata = ^avm_readdata[31:8];

  // A tick is pending while the timer sits at zero; it is consumed only by an actual poll start.
  assign start = (state == IDLE) && (timer == '0) && enable && (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push  = (state == PUSH);
  assign pop   = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      timer   <= TMR_W'(POLL_DIV - 1);
      cap_reg <= '0;
      dat_reg <= '0;
    end else begin
      state <= state_nxt;
      if (start)
        timer <= TMR_W'(POLL_DIV - 1);
      else if (timer != '0)
        timer <= timer - TMR_W'(1);
      if (state == CAP_SAMPLE)
        cap_reg <= avm_readdata[7:0];
      if (state == DAT_SAMPLE)
        dat_reg <= avm_readdata[7:0];
    end
  end

  always_comb begin
    state_nxt      = state;
    avm_address    = 2'd0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 32'd0;
    case (state)
      IDLE: if (start) state_nxt = CAP_REQ;
      CAP_REQ: begin
        avm_address    = 2'd3;
        avm_chipselect = 1'b1;
        state_nxt      = CAP_SAMPLE;
      end
      CAP_SAMPLE: begin
        avm_address    = 2'd3;
        avm_chipselect = 1'b1;
        state_nxt      = (avm_readdata[7:0] == 8'd0) ? IDLE : DAT_REQ;
      end
      DAT_REQ: begin
        avm_chipselect = 1'b1;
        state_nxt      = DAT_SAMPLE;
      end
      DAT_SAMPLE: begin
        avm_chipselect = 1'b1;
        state_nxt      = CLR;
      end
      CLR: begin
        // Clear only what was captured so later edges on other bits survive.
        avm_address    = 2'd3;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = {24'd0, cap_reg};
        state_nxt      = PUSH;
      end
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cap_reg, dat_reg};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_q     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // The head shows the last popped entry while empty instead of a stale slot.
  assign evt_valid   = (fifo_level != '0);
  assign head        = evt_valid ? mem[rd_ptr] : last_q;
  assign evt_capture = head[15:8];
  assign evt_data    = head[7:0];
  assign irq         = evt_valid;

endmodule
